// File: rtl/vga_timing_generator_pkg.sv
// Shared VGA 640x480@60 timing constants and small helpers, imported by the
// timing generator and by the image generator so both agree on the frame size.
package vga_timing_generator_pkg;

  localparam int unsigned CNT_W        = 12;

  localparam int unsigned FRAME_WIDTH  = 640;
  localparam int unsigned FRAME_HEIGHT = 480;

  localparam int unsigned H_VISIBLE    = FRAME_WIDTH;
  localparam int unsigned H_FRONT      = 16;
  localparam int unsigned H_SYNC       = 96;
  localparam int unsigned H_BACK       = 48;
  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE    = FRAME_HEIGHT;
  localparam int unsigned V_FRONT      = 10;
  localparam int unsigned V_SYNC       = 2;
  localparam int unsigned V_BACK       = 33;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [2:0]       color_t;

  // Per-pixel control bits that travel down the pipeline next to the colour.
  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
  } sync_bits_t;

  // Convert an internal active-high sync flag to the pin level.
  function automatic logic sync_level(input logic asserted, input logic active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Video bus between the timing generator (master) and the image generator /
// display sink (slave). The image generator returns a colour for the x/y it sees.
interface vga_timing_generator_if;
  import vga_timing_generator_pkg::*;

  color_t color;
  cnt_t   x;
  cnt_t   y;
  logic   vga_r;
  logic   vga_g;
  logic   vga_b;
  logic   hsync;
  logic   vsync;
  logic   blank;
  logic   frame_start;

  // Handshake: none. x/y/frame_start are valid every cycle; colour must be
  // returned combinationally in the same cycle and is taken on the next edge.
  modport master (
    input  color,
    output x, y, vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start
  );

  modport slave (
    output color,
    input  x, y, vga_r, vga_g, vga_b, hsync, vsync, blank, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One axis of the raster: a wrapping position counter plus decode of the
// visible and sync windows. Used once for pixels and once for lines.
module vga_axis_counter
  import vga_timing_generator_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output cnt_t count,
  output logic carry,
  output logic visible,
  output logic sync_win
);

  localparam int unsigned TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam cnt_t LAST       = cnt_t'(TOTAL - 1);
  localparam cnt_t VIS_END    = cnt_t'(VISIBLE);
  localparam cnt_t SYNC_START = cnt_t'(VISIBLE + FRONT);
  localparam cnt_t SYNC_STOP  = cnt_t'(VISIBLE + FRONT + SYNC);

  cnt_t count_q;
  cnt_t count_d;
  logic at_last;

  // Advance when enabled; wrap to zero after the last position.
  always_comb begin
    at_last = (count_q == LAST);
    carry   = en && at_last;
    count_d = count_q;
    if (en) begin
      count_d = at_last ? '0 : count_q + cnt_t'(1);
    end
  end

  // Position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign visible  = (count_q < VIS_END);
  assign sync_win = (count_q >= SYNC_START) && (count_q < SYNC_STOP);

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: counters -> registered x/y/frame_start (stage 1) ->
// colour/sync/blank registered together (stage 2) so RGB and sync line up.
module vga_timing_generator
  import vga_timing_generator_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = vga_timing_generator_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT         = vga_timing_generator_pkg::H_FRONT,
  parameter int unsigned H_SYNC          = vga_timing_generator_pkg::H_SYNC,
  parameter int unsigned H_BACK          = vga_timing_generator_pkg::H_BACK,
  parameter int unsigned V_VISIBLE       = vga_timing_generator_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT         = vga_timing_generator_pkg::V_FRONT,
  parameter int unsigned V_SYNC          = vga_timing_generator_pkg::V_SYNC,
  parameter int unsigned V_BACK          = vga_timing_generator_pkg::V_BACK,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic   CLOCK_25,
  input  logic   RESET,
  input  color_t color,
  output cnt_t   x,
  output cnt_t   y,
  output logic   vga_r,
  output logic   vga_g,
  output logic   vga_b,
  output logic   hsync,
  output logic   vsync,
  output logic   blank,
  output logic   frame_start
);

  cnt_t h_count;
  cnt_t v_count;
  logic h_carry;
  logic v_carry;
  logic h_vis;
  logic v_vis;
  logic h_sync_win;
  logic v_sync_win;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk      (CLOCK_25),
    .rst      (RESET),
    .en       (1'b1),
    .count    (h_count),
    .carry    (h_carry),
    .visible  (h_vis),
    .sync_win (h_sync_win)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk      (CLOCK_25),
    .rst      (RESET),
    .en       (h_carry),
    .count    (v_count),
    .carry    (v_carry),
    .visible  (v_vis),
    .sync_win (v_sync_win)
  );

  logic       active;
  cnt_t       x_q, x_d;
  cnt_t       y_q, y_d;
  logic       frame_start_q, frame_start_d;
  logic       origin_q, origin_d;
  sync_bits_t s1_q, s1_d;
  sync_bits_t s2_q, s2_d;
  color_t     rgb_q, rgb_d;

  // Next values for both pipeline stages. origin tracks "counters are at 0,0"
  // (true out of reset and after a full-frame carry), avoiding a wide compare.
  always_comb begin
    active        = h_vis && v_vis;
    x_d           = active ? h_count + cnt_t'(1) : '0;
    y_d           = active ? v_count + cnt_t'(1) : '0;
    origin_d      = v_carry;
    frame_start_d = origin_q && active;
    s1_d.blank    = !active;
    s1_d.hsync    = h_sync_win;
    s1_d.vsync    = v_sync_win;
    s2_d          = s1_q;
    rgb_d         = s1_q.blank ? '0 : color;
  end

  // Pipeline registers; reset leaves sync inactive and the screen blanked.
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      origin_q      <= 1'b1;
      s1_q          <= '{blank: 1'b1, hsync: 1'b0, vsync: 1'b0};
      s2_q          <= '{blank: 1'b1, hsync: 1'b0, vsync: 1'b0};
      rgb_q         <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      origin_q      <= origin_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      rgb_q         <= rgb_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[2];
  assign vga_g       = rgb_q[1];
  assign vga_b       = rgb_q[0];
  assign blank       = s2_q.blank;
  assign hsync       = sync_level(s2_q.hsync, SYNC_ACTIVE_LOW);
  assign vsync       = sync_level(s2_q.vsync, SYNC_ACTIVE_LOW);

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 Parameters SHALL be H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_BACK=48, V_VISIBLE=480, V_FRONT=10, V_SYNC=2 and V_BACK=33 (pixels/lines per region).
REQ-002 Parameter SYNC_ACTIVE_LOW SHALL default to 1 and set both sync outputs active-low.
REQ-003 Port CLOCK_25 SHALL be an input, 1 bit: 25 MHz pixel clock, the only clock.
REQ-004 Port RESET SHALL be an input, 1 bit: asynchronous active-high reset.
REQ-005 Port color SHALL be an input, 3 bits: pixel colour for the current x/y, driven combinationally by the image generator.
REQ-006 Port x SHALL be an output, 12 bits: 1-based pixel column, 1..640 when active, 0 when blanked.
REQ-007 Port y SHALL be an output, 12 bits: 1-based pixel row, 1..480 when active, 0 when blanked.
REQ-008 Ports vga_r, vga_g and vga_b SHALL be outputs, 1 bit each, carrying colour bits [2], [1] and [0].
REQ-009 Ports hsync and vsync SHALL be outputs, 1 bit each: sync pulses.
REQ-010 Port blank SHALL be an output, 1 bit: high outside the visible area, aligned with the RGB outputs.
REQ-011 Port frame_start SHALL be an output, 1 bit: one-cycle pulse for the first visible pixel of each frame, aligned with x/y.

Function
REQ-012 h_count SHALL run 0..799 (H total = sum of H params) and wrap to 0; v_count SHALL advance only when h_count wraps, run 0..524 and wrap to 0.
REQ-013 Active SHALL mean h_count<H_VISIBLE && v_count<V_VISIBLE; in the same cycle x=h_count+1 and y=v_count+1, else x=0 and y=0.
REQ-014 x/y SHALL be registered outputs derived from the counters, with no combinational path from counters to ports.
REQ-015 color SHALL be sampled on the CLOCK_25 edge following the presentation of x/y, and vga_r/g/b SHALL update from it one cycle after the x/y cycle (latency 1).
REQ-016 hsync, vsync and blank SHALL be delayed by one stage so they align with vga_r/g/b.
REQ-017 vga_r/g/b SHALL be forced to 0 whenever the aligned blank=1, regardless of color.
REQ-018 The hsync asserted window SHALL be h_count in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
REQ-019 The vsync asserted window SHALL be v_count in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491, for whole lines.
REQ-020 frame_start SHALL be 1 exactly when x=1 and y=1, once per 420 000 cycles.
REQ-021 Counter widths SHALL be 12 bits, and comparisons SHALL be unsigned with no overflow for any legal parameter set.
REQ-022 At the wrap of the last pixel of the last line (h=799, v=524), both counters SHALL reach 0 together on the next cycle.

Reset
REQ-023 While RESET=1: h_count=0, v_count=0, x=0, y=0, vga_r/g/b=0, hsync=vsync=inactive, blank=1, frame_start=0.
REQ-024 Reset assertion SHALL act immediately without waiting for a clock edge, and may arrive mid-line or mid-frame.
REQ-025 On the first clock after RESET deassertion, counters SHALL start at h=0,v=0, so x=1,y=1 and frame_start=1 appear in that first post-reset registered cycle.
REQ-026 The delayed sync/blank pipeline stage SHALL also reset, with no stale pulse after reset.

Structure
REQ-027 Timing constants (H_*, V_*, totals, FRAME_WIDTH/HEIGHT = 640/480) SHALL live in global_symbols.vh and be shared with the image generator.
REQ-028 One sub-module, vga_axis_counter, SHALL hold the wrap counter and visible/sync window decode, instantiated twice: h with enable=1 and v with enable=h wrap.
REQ-029 The block SHALL contain no other clocks, dividers or gated clocks.

Verification
REQ-030 Release RESET and run 800 clocks: hsync low exactly for cycles 656..751 of the line, blank aligned high for 160 cycles.
REQ-031 Run one full frame of 420 000 clocks: vsync low for 1600 clocks (lines 490..491), frame_start pulses once, then again after 420 000 clocks.
REQ-032 Drive color=3'b101 constantly: vga_r/g/b=1/0/1 one cycle after each x in 1..640 and 0 while blanked.
REQ-033 Drive color=x[2:0]: the RGB at cycle n+1 equals x(n)[2:0] for all visible pixels, proving latency 1.
REQ-034 Assert RESET asynchronously at h=300,v=200 for 3 cycles: outputs go to reset values before the next edge, and restart with x=1,y=1,frame_start=1.
REQ-035 Check the wrap at h=799,v=524: the next x/y are 1/1 with no extra line or pixel.
